q01e: RTL and testbench



---
 rtl/q01e.sv | 73 +++++++
 tb/tb_q01e.sv | 137 +++++++++++++
 2 files changed

// File: rtl/q01e.sv
// q01e: registered four-input Boolean function
//   s = (~b & c) | (~a & b & ~c) | (a & b & d)
// The combinational core is a structural network of 2-input NAND gates.
// Its result is captured every rising clk edge.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset, clears s
//   a    in   operand, MSB of index {a,b,c,d}
//   b    in   operand
//   c    in   operand
//   d    in   operand, LSB of index
//   s    out  registered function result (1-cycle latency)

module q01e_nand2 (
    input  logic x_i,
    input  logic y_i,
    output logic z_o
);
    assign z_o = ~(x_i & y_i);
endmodule

module q01e (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic s
);
    logic na, nb, nc;          // inverted operands
    logic n1;                  // ~(~b & c)
    logic x2, t2ab, n2;        // ~a & b, then ~(~a & b & ~c)
    logic y3, t3ab, n3;        // a & b, then ~(a & b & d)
    logic o12, no12;           // t1 | t2 and its inverse
    logic s_d;
    logic s_q;

    // Inverters
    q01e_nand2 u_inv_a (.x_i(a), .y_i(a), .z_o(na));
    q01e_nand2 u_inv_b (.x_i(b), .y_i(b), .z_o(nb));
    q01e_nand2 u_inv_c (.x_i(c), .y_i(c), .z_o(nc));

    // Term 1: ~b & c, kept inverted for the OR stage
    q01e_nand2 u_t1    (.x_i(nb),   .y_i(c),    .z_o(n1));

    // Term 2: ~a & b & ~c, kept inverted
    q01e_nand2 u_t2a   (.x_i(na),   .y_i(b),    .z_o(x2));
    q01e_nand2 u_t2i   (.x_i(x2),   .y_i(x2),   .z_o(t2ab));
    q01e_nand2 u_t2b   (.x_i(t2ab), .y_i(nc),   .z_o(n2));

    // Term 3: a & b & d, kept inverted
    q01e_nand2 u_t3a   (.x_i(a),    .y_i(b),    .z_o(y3));
    q01e_nand2 u_t3i   (.x_i(y3),   .y_i(y3),   .z_o(t3ab));
    q01e_nand2 u_t3b   (.x_i(t3ab), .y_i(d),    .z_o(n3));

    // 3-input OR built as two 2-input NAND-of-inverted stages:
    // the first OR result is re-inverted before joining term 3.
    q01e_nand2 u_or12  (.x_i(n1),   .y_i(n2),   .z_o(o12));
    q01e_nand2 u_or12i (.x_i(o12),  .y_i(o12),  .z_o(no12));
    q01e_nand2 u_or3   (.x_i(no12), .y_i(n3),   .z_o(s_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s_d;
        end
    end

    assign s = s_q;
endmodule

// File: tb/tb_q01e.sv
// Scoreboard bench for q01e: expected results come from the truth table
// and are queued when an index is driven, then popped one edge later.

module tb_q01e;
    logic clk;
    logic rst;
    logic a, b, c, d;
    logic s;

    int unsigned errors;
    int unsigned checks;
    logic exp_q[$];
    logic [15:0] f_tbl;

    q01e dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .s  (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply an index and queue its expected registered result.
    task automatic drive(input int unsigned idx);
        logic [3:0] v;
        v = idx[3:0];
        {a, b, c, d} = v;
        exp_q.push_back(f_tbl[v]);
    endtask

    // Wait one rising edge, then compare s against the oldest queued result.
    task automatic step_check(input string tag);
        logic e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 1'b0, 1'b1);
        end else begin
            e = exp_q.pop_front();
            check(tag, s, e);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        f_tbl  = 16'hAC3C;  // bit i = f(index i): on-set 2,3,4,5,10,11,13,15
        rst = 1'b1;
        {a, b, c, d} = 4'h0;

        // Initial reset
        #1;
        check("reset_async_init", s, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_init", s, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset with f=1 on the inputs
        drive(15);
        step_check("pre_rst_f1");
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_drop", s, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_edge", s, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            drive(i);
            step_check($sformatf("sweep_%0d", i));
        end

        // d sensitivity at a=1,b=1,c=0
        drive(12); step_check("dsens_0");
        drive(13); step_check("dsens_1");
        drive(12); step_check("dsens_2");

        // d insensitivity
        drive(2); step_check("dins_001_d0");
        drive(3); step_check("dins_001_d1");
        drive(8); step_check("dins_100_d0");
        drive(9); step_check("dins_100_d1");

        // Mid-cycle change: index 4 briefly, then 6 before the edge
        {a, b, c, d} = 4'd4;
        #3;
        drive(6);
        #2;
        check("midcyc_before_edge", s, 1'b0);
        step_check("midcyc_edge");

        // Reset mid-stream at index 11
        for (int i = 8; i < 12; i++) begin
            drive(i);
            step_check($sformatf("ms_sweep_%0d", i));
        end
        #3;
        rst = 1'b1;
        #1;
        check("ms_rst_drop", s, 1'b0);
        @(posedge clk);
        #1;
        check("ms_rst_hold", s, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 12; i < 16; i++) begin
            drive(i);
            step_check($sformatf("ms_resume_%0d", i));
        end

        check("sb_empty", (exp_q.size() == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
